// File: rtl/po_datapath.sv
// Perturb-and-observe MPPT datapath with converter PWM generation.
//
// Executes one P&O stage per one-hot strobe from the control decoder:
//   en[0] sample V/I, en[1] compute power, en[2] compare with previous power,
//   en[3] perturb duty (clamped to [D_MIN, D_MAX], reversing at the rails).
// A free-running W_DUTY-bit counter drives the PWM from a shadow copy of the
// duty, reloaded only at the end of each period.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   en     stage strobes [0] sample [1] power [2] compare [3] update
//   v_adc  unsigned panel voltage sample
//   i_adc  unsigned panel current sample
//   duty   current duty command
//   dir    perturbation direction (1 = increase)
//   p_out  last computed power, full 2*W_ADC width
//   upd    one-cycle pulse the cycle after each en[3]
//   pwm    registered PWM output
module po_datapath #(
  parameter int unsigned W_ADC  = 12,
  parameter int unsigned W_DUTY = 10,
  parameter int unsigned STEP   = 4,
  parameter int unsigned D_MIN  = 51,
  parameter int unsigned D_MAX  = 972,
  parameter int unsigned D_INIT = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           en,
  input  logic [W_ADC-1:0]     v_adc,
  input  logic [W_ADC-1:0]     i_adc,
  output logic [W_DUTY-1:0]    duty,
  output logic                 dir,
  output logic [2*W_ADC-1:0]   p_out,
  output logic                 upd,
  output logic                 pwm
);

  // One extra bit so the step arithmetic can neither wrap nor underflow.
  localparam logic [W_DUTY:0]   StepX  = (W_DUTY+1)'(STEP);
  localparam logic [W_DUTY:0]   DMinX  = (W_DUTY+1)'(D_MIN);
  localparam logic [W_DUTY:0]   DMaxX  = (W_DUTY+1)'(D_MAX);
  localparam logic [W_DUTY-1:0] DMin   = W_DUTY'(D_MIN);
  localparam logic [W_DUTY-1:0] DMax   = W_DUTY'(D_MAX);
  localparam logic [W_DUTY-1:0] DInit  = W_DUTY'(D_INIT);

  logic [W_ADC-1:0]   v_s, i_s;
  logic [2*W_ADC-1:0] p_prev;
  logic               valid;
  logic [W_DUTY-1:0]  cnt;
  logic [W_DUTY-1:0]  shadow;

  logic [W_DUTY:0]    duty_up;
  logic [W_DUTY:0]    duty_dn;
  logic               sat_hi;
  logic               sat_lo;

  always_comb begin
    duty_up = {1'b0, duty} + StepX;
    duty_dn = {1'b0, duty} - StepX;
    sat_hi  = duty_up > DMaxX;
    // Compare before subtracting so a small duty never wraps past zero.
    sat_lo  = {1'b0, duty} < (DMinX + StepX);
  end

  // P&O datapath. Each strobe reads pre-edge values, so concurrent strobes
  // behave as a pipeline (e.g. en[0]|en[1] multiplies the previous sample).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s    <= '0;
      i_s    <= '0;
      p_out  <= '0;
      p_prev <= '0;
      valid  <= 1'b0;
      dir    <= 1'b1;
      duty   <= DInit;
      upd    <= 1'b0;
    end else begin
      upd <= en[3];
      if (en[0]) begin
        v_s <= v_adc;
        i_s <= i_adc;
      end
      if (en[1]) begin
        p_out <= {{W_ADC{1'b0}}, v_s} * {{W_ADC{1'b0}}, i_s};
      end
      if (en[2]) begin
        // First compare after reset only seeds the reference power.
        if (valid && (p_out < p_prev)) begin
          dir <= ~dir;
        end
        p_prev <= p_out;
        valid  <= 1'b1;
      end
      if (en[3]) begin
        if (dir) begin
          if (sat_hi) begin
            duty <= DMax;
            dir  <= 1'b0;
          end else begin
            duty <= duty_up[W_DUTY-1:0];
          end
        end else begin
          if (sat_lo) begin
            duty <= DMin;
            dir  <= 1'b1;
          end else begin
            duty <= duty_dn[W_DUTY-1:0];
          end
        end
      end
    end
  end

  // PWM: shadow reloads on the last count so a period is never split between
  // two duty values; high time per period equals shadow clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      shadow <= DInit;
      pwm    <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      pwm <= cnt < shadow;
      if (&cnt) begin
        shadow <= duty;
      end
    end
  end

endmodule

// File: tb/tb_po_datapath.sv
// Self-checking bench for po_datapath: a behavioural model tracks the P&O
// rules and PWM period arithmetic, every cycle's outputs are compared against
// it, and literal expectations from hand calculation pin the model.
module tb_po_datapath;

  localparam int W_ADC  = 12;
  localparam int W_DUTY = 10;
  localparam int STEP   = 4;
  localparam int D_MIN  = 51;
  localparam int D_MAX  = 972;
  localparam int D_INIT = 512;
  localparam int PER    = 1 << W_DUTY;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [3:0]          en = 4'd0;
  logic [W_ADC-1:0]    v_adc = '0;
  logic [W_ADC-1:0]    i_adc = '0;
  logic [W_DUTY-1:0]   duty;
  logic                dir;
  logic [2*W_ADC-1:0]  p_out;
  logic                upd;
  logic                pwm;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  po_datapath #(
    .W_ADC (W_ADC),
    .W_DUTY(W_DUTY),
    .STEP  (STEP),
    .D_MIN (D_MIN),
    .D_MAX (D_MAX),
    .D_INIT(D_INIT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .v_adc(v_adc),
    .i_adc(i_adc),
    .duty (duty),
    .dir  (dir),
    .p_out(p_out),
    .upd  (upd),
    .pwm  (pwm)
  );

  // Behavioural model state.
  longint m_vs, m_is, m_p, m_pprev;
  int     m_valid, m_dir, m_duty, m_upd, m_pwm;
  longint m_n;       // clock edges since reset release
  int     m_shadow;  // duty in force for the current PWM period

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vs = 0; m_is = 0; m_p = 0; m_pprev = 0; m_valid = 0;
    m_dir = 1; m_duty = D_INIT; m_upd = 0; m_pwm = 0;
    m_n = 0; m_shadow = D_INIT;
  endtask

  task automatic model_step(input logic [3:0] e, input int v, input int i);
    longint ovs, ois, op, opp;
    int od, odir, phase;
    ovs = m_vs; ois = m_is; op = m_p; opp = m_pprev; od = m_duty; odir = m_dir;
    if (e[0]) begin m_vs = v; m_is = i; end
    if (e[1]) m_p = ovs * ois;
    if (e[2]) begin
      if (m_valid != 0 && op < opp) m_dir = 1 - odir;
      m_pprev = op;
      m_valid = 1;
    end
    if (e[3]) begin
      if (odir == 1) begin
        if (od + STEP > D_MAX) begin m_duty = D_MAX; m_dir = 0; end
        else m_duty = od + STEP;
      end else begin
        if (od - STEP < D_MIN) begin m_duty = D_MIN; m_dir = 1; end
        else m_duty = od - STEP;
      end
    end
    m_upd = e[3] ? 1 : 0;
    // PWM: position within the period is simply edges-since-reset mod period.
    phase = int'(m_n % PER);
    m_pwm = (phase < m_shadow) ? 1 : 0;
    if (phase == PER - 1) m_shadow = od;
    m_n++;
  endtask

  task automatic compare_all();
    chk("duty", longint'(duty), m_duty);
    chk("dir", longint'(dir), m_dir);
    chk("p_out", longint'(p_out), m_p);
    chk("upd", longint'(upd), m_upd);
    chk("pwm", longint'(pwm), m_pwm);
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at
  // the next falling edge.
  task automatic cycle(input logic [3:0] e, input int v, input int i);
    if (e[2] && e[3]) begin
      failures++;
      $display("FAIL protocol: en[2] and en[3] driven together at %0t", $time);
    end
    en = e;
    v_adc = W_ADC'(v);
    i_adc = W_ADC'(i);
    @(posedge clk);
    model_step(e, v, i);
    @(negedge clk);
    compare_all();
    en = 4'd0;
  endtask

  task automatic iter(input int v, input int i);
    cycle(4'b0001, v, i);
    cycle(4'b0010, v, i);
    cycle(4'b0100, v, i);
    cycle(4'b1000, v, i);
  endtask

  // Asynchronous reset away from the clock edge, checked before any edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_duty", longint'(duty), 512);
    chk("rst_dir", longint'(dir), 1);
    chk("rst_pwm", longint'(pwm), 0);
    chk("rst_upd", longint'(upd), 0);
    chk("rst_p_out", longint'(p_out), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    int guard;
    int hi [2];
    logic [3:0] e;

    @(negedge clk);
    do_reset();

    // Rising power keeps dir and steps duty up.
    iter(100, 100);
    chk("rise_p0", longint'(p_out), 10000);
    chk("rise_d0", longint'(duty), 516);
    iter(100, 110);
    chk("rise_p1", longint'(p_out), 11000);
    chk("rise_d1", longint'(duty), 520);
    iter(100, 120);
    chk("rise_p2", longint'(p_out), 12000);
    chk("rise_d2", longint'(duty), 524);
    chk("rise_dir", longint'(dir), 1);

    // Falling power reverses; equal power keeps the direction.
    iter(100, 100);
    chk("fall_dir", longint'(dir), 0);
    chk("fall_d", longint'(duty), 520);
    iter(100, 100);
    chk("eq_dir", longint'(dir), 0);
    chk("eq_d", longint'(duty), 516);

    // Full-scale product.
    iter(4095, 4095);
    chk("max_p", longint'(p_out), 16769025);
    chk("max_d", longint'(duty), 512);

    // Walk duty down to 256 with update strobes alone.
    for (int k = 0; k < 64; k++) cycle(4'b1000, 0, 0);
    chk("d256", longint'(duty), 256);
    cycle(4'b0000, 0, 0);
    guard = 0;
    while ((m_n % PER) != 0 && guard < 3 * PER) begin
      cycle(4'b0000, 0, 0);
      guard++;
    end
    chk("align_timeout", longint'(m_n % PER), 0);

    // Two PWM periods; a compare with low power flips dir mid-period, then an
    // update to 260 must only show in the second period.
    hi[0] = 0;
    hi[1] = 0;
    for (int k = 0; k < 2 * PER; k++) begin
      case (k)
        300:     e = 4'b0001;
        301:     e = 4'b0010;
        302:     e = 4'b0100;
        500:     e = 4'b1000;
        default: e = 4'b0000;
      endcase
      cycle(e, 1, 1);
      if (pwm) hi[k / PER]++;
    end
    chk("pwm_hi_256", hi[0], 256);
    chk("pwm_hi_260", hi[1], 260);
    chk("d260", longint'(duty), 260);

    // Upper saturation.
    guard = 0;
    while (m_duty < D_MAX && guard < 400) begin
      cycle(4'b1000, 0, 0);
      guard++;
    end
    chk("d972", longint'(duty), 972);
    cycle(4'b1000, 0, 0);
    chk("sat_hi_d", longint'(duty), 972);
    chk("sat_hi_dir", longint'(dir), 0);
    cycle(4'b1000, 0, 0);
    chk("sat_hi_next", longint'(duty), 968);

    // Lower saturation.
    guard = 0;
    while (m_duty > 52 && guard < 400) begin
      cycle(4'b1000, 0, 0);
      guard++;
    end
    chk("d52", longint'(duty), 52);
    cycle(4'b1000, 0, 0);
    chk("sat_lo_d", longint'(duty), 51);
    chk("sat_lo_dir", longint'(dir), 1);
    cycle(4'b1000, 0, 0);
    chk("sat_lo_next", longint'(duty), 55);

    // Concurrent sample+power uses the previous sample (1*1).
    cycle(4'b0011, 7, 9);
    chk("pipe_p_old", longint'(p_out), 1);
    cycle(4'b0010, 0, 0);
    chk("pipe_p_new", longint'(p_out), 63);

    // Mid-period reset, then a fresh iteration from the reset state.
    for (int k = 0; k < 37; k++) cycle(4'b0000, 0, 0);
    do_reset();
    iter(10, 10);
    chk("post_rst_p", longint'(p_out), 100);
    chk("post_rst_d", longint'(duty), 516);
    for (int k = 0; k < 8; k++) cycle(4'b0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/po_datapath.md
# po_datapath

Perturb-and-observe MPPT datapath, directly downstream of the core control FSM's decoder. Consumes the four one-hot enable strobes `en[3:0]` and executes one P&O stage per strobe: sample V/I, compute power, compare with the previous power, update duty. It also generates the converter PWM from the resulting duty cycle, so it is the last stage before the gate driver.

## Interface
- `W_ADC`, 12: width of voltage and current samples.
- `W_DUTY`, 10: duty and PWM counter width. PWM period is 2^W_DUTY clocks.
- `STEP`, 4: duty perturbation step, in LSBs.
- `D_MIN`, 51: lowest allowed duty.
- `D_MAX`, 972: highest allowed duty.
- `D_INIT`, 512: duty after reset.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  4  stage strobes from the decoder: [0] sample, [1] power, [2] compare, [3] update.
- `v_adc`  in  W_ADC  unsigned panel voltage sample.
- `i_adc`  in  W_ADC  unsigned panel current sample.
- `duty`  out  W_DUTY  current duty command.
- `dir`  out  1  perturbation direction: 1 = increase, 0 = decrease.
- `p_out`  out  2*W_ADC  last computed power.
- `upd`  out  1  one-cycle pulse, asserted the cycle after each en[3].
- `pwm`  out  1  registered PWM output.

## Operation
- Reset values: duty=D_INIT, dir=1, p_out=0, upd=0, pwm=0. Internal registers: v_s=0, i_s=0, p_prev=0, valid=0, pwm counter=0, shadow duty=D_INIT.
- en[0]: v_s <= v_adc, i_s <= i_adc.
- en[1]: p_out <= v_s*i_s, unsigned, full 2*W_ADC width, no truncation.
- en[2] with valid=0: p_prev <= p_out and valid <= 1. dir is unchanged.
- en[2] with valid=1:
  - p_out < p_prev: dir <= ~dir.
  - p_out >= p_prev: dir holds, so equal power keeps the direction.
  - In both cases p_prev <= p_out.
- en[3], dir=1: duty <= min(duty+STEP, D_MAX). If the unclamped sum exceeds D_MAX (computed W_DUTY+1 wide), duty <= D_MAX and dir <= 0.
- en[3], dir=0: duty <= max(duty-STEP, D_MIN). If the unclamped difference is below D_MIN (signed or W_DUTY+1 wide, no wrap), duty <= D_MIN and dir <= 1.
- Saturation reversal overrides nothing else: en[2] and en[3] in the same cycle is not supported (see Timing).
- Each en bit acts independently. Several bits in one cycle each use pre-edge register values, with pipeline semantics.
- en=0: all datapath registers hold.
- PWM:
  - Free-running counter 0..2^W_DUTY-1; wraps to 0.
  - Shadow duty loads `duty` only when the counter equals 2^W_DUTY-1, so there is no mid-period glitch.
  - pwm <= (counter < shadow).
- Reset mid-operation: all registers return to reset values immediately, independent of clk. The first en[2] after reset is again a load-only compare (valid=0).

## Timing
- All outputs are registered and change only on the rising edge of clk, except on asynchronous reset.
- en[k] sampled at edge N takes effect at edge N, visible after N.
- upd is high for exactly the cycle following the en[3] edge.
- Minimum spacing is one cycle per stage; a full P&O iteration is 4 clocks when strobes are back-to-back.
- en[2] and en[3] are never concurrent. The decoder's one-hot sequencing guarantees this. The bench flags concurrency as a protocol error and does not check results.
- A duty change reaches pwm at the first counter wrap after the update, plus 1 clk. The worst case is 2^W_DUTY+1 clocks.
- pwm high time per period equals shadow duty clocks exactly. duty=0 cannot occur because D_MIN > 0.

## Test plan
- Reset: assert rst mid-period -> duty=512, dir=1, pwm=0, upd=0, p_out=0 immediately. After release the counter restarts at 0.
- Rising power: iterations with (v,i) = (100,100), (100,110), (100,120) -> p_out = 10000, 11000, 12000. dir stays 1 and duty goes 512 -> 516 -> 520 -> 524. upd pulses once per iteration.
- Falling power: after a 12000 iteration, apply (100,100) -> p_out=10000, dir flips to 0, next duty = previous - 4. An equal-power iteration keeps dir.
- Saturation: preload duty near max by iterating with rising power until duty=972 -> the next en[3] holds duty at 972 and dir becomes 0. The next update gives 968. The mirror case at D_MIN=51 flips dir to 1.
- PWM: duty=256 -> pwm high for exactly 256 of every 1024 clocks. An update to 260 mid-period takes effect only from the next period.
- Max values: v=i=4095 -> p_out = 16769025, with no overflow in the 24-bit width.
